// File: rtl/mat_maven_pkg.sv
// Shared definitions for the matrix-multiply result path: frame constants,
// transmit state encoding, the buffered result entry and frame byte helpers.
package mat_maven_pkg;

    localparam logic [7:0] FRAME_SOF = 8'hFE;
    localparam int         FRAME_LEN = 7;
    localparam int         ENTRY_W   = 40;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } tx_state_t;

    // Job ID sits in the top byte so the packed entry reads {job, c11, c12, c21, c22}.
    typedef struct packed {
        logic [7:0] job;
        logic [7:0] c11;
        logic [7:0] c12;
        logic [7:0] c21;
        logic [7:0] c22;
    } result_entry_t;

    // Modulo-256 sum of the payload bytes; the start-of-frame byte is not included.
    function automatic logic [7:0] entry_checksum(input result_entry_t e);
        return e.job + e.c11 + e.c12 + e.c21 + e.c22;
    endfunction

    // Byte at position idx of the 7-byte frame built from entry e.
    function automatic logic [7:0] frame_byte(input result_entry_t e,
                                              input logic [2:0]    idx,
                                              input logic [7:0]    csum);
        case (idx)
            3'd0:    return FRAME_SOF;
            3'd1:    return e.job;
            3'd2:    return e.c11;
            3'd3:    return e.c12;
            3'd4:    return e.c21;
            3'd5:    return e.c22;
            3'd6:    return csum;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding completed results until the transmitter
// is ready to frame them. Full/empty come from an occupancy count one bit
// wider than the address so that DEPTH entries can all be used.
import mat_maven_pkg::*;

module result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int ADDR = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR-1:0]    wr_ptr;
    logic [ADDR-1:0]    rd_ptr;
    logic [ADDR:0]      count;
    logic               push;
    logic               pop;

    // A write is refused when full even if a read frees a slot in the same cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == (ADDR+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/result_tx.sv
// Frames buffered matrix results onto the UART as 7-byte packets:
// FE, job, c11, c12, c21, c22, checksum. Each byte waits for the UART to
// be idle, and the cycle after every request is spent in HOLD so the
// UART has time to raise busy before the next byte is considered.
import mat_maven_pkg::*;

module result_tx #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [7:0]  res_job,
    input  logic [7:0]  res_c11,
    input  logic [7:0]  res_c12,
    input  logic [7:0]  res_c21,
    input  logic [7:0]  res_c22,
    output logic [7:0]  tx_byte,
    output logic        send_request,
    input  logic        busy,
    output logic        tx_active,
    output logic [15:0] frames_sent
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    tx_state_t          state;
    tx_state_t          state_next;
    result_entry_t      frame_q;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [2:0]         idx_q;
    logic [15:0]        frame_count;
    logic [7:0]         checksum;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               issue_byte;
    logic               advance;
    logic               frame_done;

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (res_valid),
        .wr_data ({res_job, res_c11, res_c12, res_c21, res_c22}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign res_ready   = !fifo_full;
    assign checksum    = entry_checksum(frame_q);
    assign tx_active   = (state != IDLE);
    assign frames_sent = frame_count;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and per-cycle control strobes for the frame sequencer.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue_byte = 1'b0;
        advance    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!busy) begin
                    issue_byte = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (idx_q == LAST_IDX) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    advance    = 1'b1;
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame register, byte index, registered UART outputs and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q      <= '0;
            idx_q        <= '0;
            tx_byte      <= 8'h00;
            send_request <= 1'b0;
            frame_count  <= '0;
        end else begin
            send_request <= issue_byte;
            if (pop) begin
                frame_q <= result_entry_t'(fifo_rd_data);
                idx_q   <= '0;
            end
            if (issue_byte) tx_byte <= frame_byte(frame_q, idx_q, checksum);
            if (advance)    idx_q <= idx_q + 1'b1;
            if (frame_done) frame_count <= frame_count + 1'b1;
        end
    end

endmodule
